xcvr_spi_slave: RTL and testbench

XCVR_SPI_SLAVE -- requirements
Module: xcvr_spi_slave

---
 rtl/xcvr_spi_slave_pkg.sv | 8 +
 rtl/xcvr_spi_slave_fifo.sv | 63 ++++++
 rtl/xcvr_spi_slave.sv | 184 ++++++++++++++++++
 tb/tb_xcvr_spi_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_spi_slave_pkg.sv
// Shared constants for the SPI slave transceiver and its FIFOs.
package xcvr_spi_slave_pkg;

    localparam int SYNC_STAGES   = 2;
    localparam int BITS_PER_BYTE = 8;
    localparam int BIT_COUNT_W   = $clog2(BITS_PER_BYTE);

endpackage

// File: rtl/xcvr_spi_slave_fifo.sv
// Team Fifo: synchronous show-ahead FIFO; head reads as zero while empty.
module Fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             empty_o,
    output logic             halfFull_o,
    output logic             full_o
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] HALF_COUNT = (LOG2_DEPTH + 1)'(DEPTH / 2);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wrPtr_q;
    logic [LOG2_DEPTH-1:0] rdPtr_q;
    logic [LOG2_DEPTH:0]   count_q;
    logic                  popOk;
    logic                  pushOk;

    // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
    assign popOk  = pop_i & ~empty_o;
    assign pushOk = push_i & (~full_o | popOk);

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_COUNT);
    assign halfFull_o = (count_q >= HALF_COUNT);
    assign popData_o  = empty_o ? '0 : mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/xcvr_spi_slave.sv
// SPI slave with TX/RX byte FIFOs, all four SPI modes, sticky overrun/underrun flags.
module xcvr_spi_slave
    import xcvr_spi_slave_pkg::*;
#(
    parameter int LOG2_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataIn,
    input  logic       write,
    input  logic       read,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       clrErr,
    input  logic       sck,
    input  logic       mosi,
    input  logic       nCs,
    output logic       miso,
    output logic       misoEn,
    output logic       txDataPresent,
    output logic       txHalfFull,
    output logic       txFull,
    output logic       rxDataPresent,
    output logic       rxHalfFull,
    output logic       rxFull,
    output logic [7:0] dataOut,
    output logic       overrun,
    output logic       underrun
);

    localparam logic [BIT_COUNT_W-1:0] LAST_BIT = BIT_COUNT_W'(BITS_PER_BYTE - 1);

    logic [SYNC_STAGES-1:0]   sckSync_q, mosiSync_q, nCsSync_q;
    logic                     sckS, mosiS, nCsS;
    logic                     sckPrev_q, nCsPrev_q, armed_q, misoEn_q;
    logic [BITS_PER_BYTE-1:0] txShift_q, txShift_d, rxShift_q, rxShift_d;
    logic [BIT_COUNT_W-1:0]   bitCount_q, bitCount_d;
    logic                     loadPending_q, loadPending_d;
    logic                     firstByte_q, firstByte_d;
    logic                     rxPush_q, rxPush_d;
    logic                     overrun_q, underrun_q;

    logic                     selected, csFall;
    logic                     sckRise, sckFall, leadingEdge, trailingEdge;
    logic                     sampleEdge, shiftEdge, doLoad, txPop;
    logic [BITS_PER_BYTE-1:0] txHead, rxHead;
    logic                     txEmpty, txHalf, txFullInt;
    logic                     rxEmpty, rxHalf, rxFullInt;

    // nCs chain resets to "selected" so a frame already running at reset cannot arm the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            sckSync_q  <= '0;
            mosiSync_q <= '0;
            nCsSync_q  <= '0;
        end else begin
            sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
            nCsSync_q  <= {nCsSync_q[SYNC_STAGES-2:0], nCs};
        end
    end

    assign sckS  = sckSync_q[SYNC_STAGES-1];
    assign mosiS = mosiSync_q[SYNC_STAGES-1];
    assign nCsS  = nCsSync_q[SYNC_STAGES-1];

    assign selected     = armed_q & ~nCsS;
    assign csFall       = armed_q & nCsPrev_q & ~nCsS;
    assign sckRise      = sckS & ~sckPrev_q;
    assign sckFall      = ~sckS & sckPrev_q;
    assign leadingEdge  = cpol ? sckFall : sckRise;
    assign trailingEdge = cpol ? sckRise : sckFall;
    assign sampleEdge   = selected & (cpha ? trailingEdge : leadingEdge);
    assign shiftEdge    = selected & (cpha ? leadingEdge : trailingEdge);

    // With cpha=0 the first byte must be on miso before the first edge, so it loads immediately.
    assign doLoad = selected & ~csFall & loadPending_q & (shiftEdge | (firstByte_q & ~cpha));
    assign txPop  = doLoad & ~txEmpty;

    always_comb begin
        txShift_d     = txShift_q;
        rxShift_d     = rxShift_q;
        bitCount_d    = bitCount_q;
        loadPending_d = loadPending_q;
        firstByte_d   = firstByte_q;
        rxPush_d      = 1'b0;
        if (csFall) begin
            bitCount_d    = '0;
            loadPending_d = 1'b1;
            firstByte_d   = 1'b1;
        end else begin
            if (doLoad) begin
                txShift_d     = txEmpty ? '0 : txHead;
                loadPending_d = 1'b0;
                firstByte_d   = 1'b0;
            end else if (shiftEdge) begin
                txShift_d = {txShift_q[BITS_PER_BYTE-2:0], 1'b0};
            end
            if (sampleEdge) begin
                rxShift_d  = {rxShift_q[BITS_PER_BYTE-2:0], mosiS};
                bitCount_d = bitCount_q + 1'b1;
                if (bitCount_q == LAST_BIT) begin
                    rxPush_d      = 1'b1;
                    loadPending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sckPrev_q     <= 1'b0;
            nCsPrev_q     <= 1'b0;
            armed_q       <= 1'b0;
            misoEn_q      <= 1'b0;
            txShift_q     <= '0;
            rxShift_q     <= '0;
            bitCount_q    <= '0;
            loadPending_q <= 1'b0;
            firstByte_q   <= 1'b0;
            rxPush_q      <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sckPrev_q     <= sckS;
            nCsPrev_q     <= nCsS;
            if (nCsS) begin
                armed_q <= 1'b1;
            end
            misoEn_q      <= selected;
            txShift_q     <= txShift_d;
            rxShift_q     <= rxShift_d;
            bitCount_q    <= bitCount_d;
            loadPending_q <= loadPending_d;
            firstByte_q   <= firstByte_d;
            rxPush_q      <= rxPush_d;
            overrun_q     <= (rxPush_q & rxFullInt & ~read) | (overrun_q & ~clrErr);
            underrun_q    <= (doLoad & txEmpty) | (underrun_q & ~clrErr);
        end
    end

    Fifo #(
        .WIDTH      (BITS_PER_BYTE),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) txFifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (write),
        .pushData_i (dataIn),
        .pop_i      (txPop),
        .popData_o  (txHead),
        .empty_o    (txEmpty),
        .halfFull_o (txHalf),
        .full_o     (txFullInt)
    );

    Fifo #(
        .WIDTH      (BITS_PER_BYTE),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) rxFifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rxPush_q),
        .pushData_i (rxShift_q),
        .pop_i      (read),
        .popData_o  (rxHead),
        .empty_o    (rxEmpty),
        .halfFull_o (rxHalf),
        .full_o     (rxFullInt)
    );

    assign miso          = txShift_q[BITS_PER_BYTE-1];
    assign misoEn        = misoEn_q;
    assign txDataPresent = ~txEmpty;
    assign txHalfFull    = txHalf;
    assign txFull        = txFullInt;
    assign rxDataPresent = ~rxEmpty;
    assign rxHalfFull    = rxHalf;
    assign rxFull        = rxFullInt;
    assign dataOut       = rxHead;
    assign overrun       = overrun_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_xcvr_spi_slave.sv
// Bench for xcvr_spi_slave: bit-banged SPI master plus a byte-level queue model of both FIFOs.
module tb_xcvr_spi_slave;

    localparam int DEPTH_A = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataIn;
    logic       write, read, cpol, cpha, clrErr, sck, mosi, nCsA, nCsB, writeB, readB;

    logic       misoA, misoEnA, txDpA, txHfA, txFA, rxDpA, rxHfA, rxFA, overrunA, underrunA;
    logic [7:0] dataOutA;
    logic       misoB, misoEnB, txDpB, txHfB, txFB, rxDpB, rxHfB, rxFB, overrunB, underrunB;
    logic [7:0] dataOutB;

    logic [7:0] txModelQ[$];
    logic [7:0] rxModelQ[$];
    logic [7:0] expMiso[$];
    logic [7:0] mosiBytes[$];
    logic [7:0] misoBytes[$];
    logic       expUnderrun, expOverrun, misoEnSeen, useSmall;
    int         nCompared = 0;
    int         nMismatched = 0;

    always #5 clk = ~clk;

    xcvr_spi_slave dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .write(write), .read(read),
        .cpol(cpol), .cpha(cpha), .clrErr(clrErr), .sck(sck), .mosi(mosi), .nCs(nCsA),
        .miso(misoA), .misoEn(misoEnA),
        .txDataPresent(txDpA), .txHalfFull(txHfA), .txFull(txFA),
        .rxDataPresent(rxDpA), .rxHalfFull(rxHfA), .rxFull(rxFA),
        .dataOut(dataOutA), .overrun(overrunA), .underrun(underrunA)
    );

    xcvr_spi_slave #(.LOG2_DEPTH(1)) dutSmall (
        .clk(clk), .rst(rst), .dataIn(dataIn), .write(writeB), .read(readB),
        .cpol(cpol), .cpha(cpha), .clrErr(clrErr), .sck(sck), .mosi(mosi), .nCs(nCsB),
        .miso(misoB), .misoEn(misoEnB),
        .txDataPresent(txDpB), .txHalfFull(txHfB), .txFull(txFB),
        .rxDataPresent(rxDpB), .rxHalfFull(rxHfB), .rxFull(rxFB),
        .dataOut(dataOutB), .overrun(overrunB), .underrun(underrunB)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeTx(input logic [7:0] b);
        dataIn = b;
        write  = 1'b1;
        waitClk(1);
        write  = 1'b0;
        txModelQ.push_back(b);
    endtask

    task automatic clearErrors();
        clrErr = 1'b1;
        waitClk(1);
        clrErr = 1'b0;
        waitClk(1);
        expUnderrun = 1'b0;
        expOverrun  = 1'b0;
        checkOutput("underrun cleared", underrunA, 0);
        checkOutput("overrun cleared", overrunA, 0);
    endtask

    // Master side of one frame; cpol/cpha already set, mosiBytes holds the bytes to send.
    task automatic applyStimulus(input int nBits, input int halfClk, input int rstAtBit);
        logic [7:0] cur;
        logic [7:0] rxb;
        rxb = '0;
        misoBytes.delete();
        misoEnSeen = 1'b0;
        sck = cpol;
        waitClk(4);
        if (useSmall) nCsB = 1'b0; else nCsA = 1'b0;
        waitClk(2 * halfClk);
        misoEnSeen = useSmall ? misoEnB : misoEnA;
        for (int i = 0; i < nBits; i++) begin
            cur = mosiBytes[i / 8];
            if (i == rstAtBit) begin
                rst = 1'b1;
                waitClk(2);
                rst = 1'b0;
            end
            if (!cpha) begin
                mosi = cur[7 - (i % 8)];
                waitClk(halfClk);
                sck = ~cpol;
                rxb = {rxb[6:0], (useSmall ? misoB : misoA)};
                waitClk(halfClk);
                sck = cpol;
            end else begin
                waitClk(halfClk);
                sck = ~cpol;
                mosi = cur[7 - (i % 8)];
                waitClk(halfClk);
                rxb = {rxb[6:0], (useSmall ? misoB : misoA)};
                sck = cpol;
            end
            if ((i % 8) == 7) misoBytes.push_back(rxb);
        end
        waitClk(halfClk);
        nCsA = 1'b1;
        nCsB = 1'b1;
        waitClk(2 * halfClk + 6);
    endtask

    // Byte-level expectation: cpha=0 loads once at select and once after every whole byte,
    // cpha=1 loads once per byte started; each whole byte received is offered to the RX FIFO.
    task automatic modelFrame(input int nBits);
        int nLoads;
        logic [7:0] v;
        nLoads = cpha ? (nBits + 7) / 8 : nBits / 8 + 1;
        expMiso.delete();
        for (int l = 0; l < nLoads; l++) begin
            if (txModelQ.size() > 0) v = txModelQ.pop_front();
            else begin
                v = 8'h00;
                expUnderrun = 1'b1;
            end
            if (l < nBits / 8) expMiso.push_back(v);
        end
        for (int k = 0; k < nBits / 8; k++) begin
            if (rxModelQ.size() < DEPTH_A) rxModelQ.push_back(mosiBytes[k]);
            else expOverrun = 1'b1;
        end
    endtask

    task automatic runFrameA(input int mode, input int nBits, input int halfClk, input string name);
        cpol = mode[1];
        cpha = mode[0];
        useSmall = 1'b0;
        modelFrame(nBits);
        applyStimulus(nBits, halfClk, -1);
        checkOutput($sformatf("%s misoEn during frame", name), misoEnSeen, 1);
        checkOutput($sformatf("%s misoEn after frame", name), misoEnA, 0);
        checkOutput($sformatf("%s miso byte count", name), misoBytes.size(), expMiso.size());
        for (int k = 0; k < expMiso.size() && k < misoBytes.size(); k++)
            checkOutput($sformatf("%s miso byte %0d", name, k), misoBytes[k], expMiso[k]);
        checkOutput($sformatf("%s underrun", name), underrunA, expUnderrun);
        checkOutput($sformatf("%s overrun", name), overrunA, expOverrun);
        checkOutput($sformatf("%s txDataPresent", name), txDpA, txModelQ.size() != 0);
        checkOutput($sformatf("%s txHalfFull", name), txHfA, txModelQ.size() >= DEPTH_A / 2);
        checkOutput($sformatf("%s rxDataPresent", name), rxDpA, rxModelQ.size() != 0);
        checkOutput($sformatf("%s rxFull", name), rxFA, rxModelQ.size() == DEPTH_A);
        while (rxModelQ.size() > 0) begin
            checkOutput($sformatf("%s rx byte", name), dataOutA, rxModelQ.pop_front());
            read = 1'b1;
            waitClk(1);
            read = 1'b0;
        end
        checkOutput($sformatf("%s rx drained", name), rxDpA, 0);
        checkOutput($sformatf("%s dataOut idle", name), dataOutA, 0);
    endtask

    initial begin
        int m, half, nW, nBytes, nBits;
        rst = 1'b1; dataIn = '0; write = 0; read = 0; cpol = 0; cpha = 0; clrErr = 0;
        sck = 0; mosi = 0; nCsA = 1; nCsB = 1; writeB = 0; readB = 0; useSmall = 0;
        expUnderrun = 0; expOverrun = 0;
        waitClk(4);
        checkOutput("reset miso", misoA, 0);
        checkOutput("reset misoEn", misoEnA, 0);
        checkOutput("reset status", {txDpA, txHfA, txFA, rxDpA, rxHfA, rxFA}, 0);
        checkOutput("reset dataOut", dataOutA, 0);
        checkOutput("reset flags", {overrunA, underrunA}, 0);
        rst = 1'b0;
        waitClk(4);

        $display("[TB] mode 0 single byte");
        writeTx(8'hA5);
        mosiBytes = '{8'h3C};
        runFrameA(0, 8, 8, "mode0 A5/3C");
        clearErrors();

        $display("[TB] modes 1..3 three-byte frames");
        for (int md = 1; md <= 3; md++) begin
            writeTx(8'h11); writeTx(8'h22); writeTx(8'h33);
            mosiBytes = '{8'h01, 8'h80, 8'hFF};
            runFrameA(md, 24, 6, $sformatf("mode%0d", md));
            clearErrors();
        end

        $display("[TB] underrun with empty TX");
        mosiBytes = '{8'hC6, 8'h39};
        runFrameA(0, 16, 6, "underrun");
        clearErrors();

        $display("[TB] frame aborted after 5 bits");
        writeTx(8'h4B);
        mosiBytes = '{8'hFF};
        runFrameA(0, 5, 6, "abort");
        writeTx(8'hD2);
        mosiBytes = '{8'h5A};
        runFrameA(0, 8, 6, "after abort");
        clearErrors();

        $display("[TB] small RX FIFO overrun");
        cpol = 0; cpha = 0; useSmall = 1'b1;
        mosiBytes = '{8'h12, 8'h34, 8'h56};
        applyStimulus(24, 6, -1);
        checkOutput("small rxFull", rxFB, 1);
        checkOutput("small overrun", overrunB, 1);
        checkOutput("small head 0", dataOutB, 8'h12);
        readB = 1'b1; waitClk(1); readB = 1'b0;
        checkOutput("small head 1", dataOutB, 8'h34);
        readB = 1'b1; waitClk(1); readB = 1'b0;
        checkOutput("small drained", rxDpB, 0);
        useSmall = 1'b0;
        clearErrors();

        $display("[TB] reset in mid-frame");
        cpol = 0; cpha = 0;
        writeTx(8'hE7);
        mosiBytes = '{8'hAA, 8'h55};
        applyStimulus(16, 6, 4);
        txModelQ.delete(); rxModelQ.delete();
        expUnderrun = 0; expOverrun = 0;
        checkOutput("post-reset rxDataPresent", rxDpA, 0);
        checkOutput("post-reset txDataPresent", txDpA, 0);
        checkOutput("post-reset underrun", underrunA, 0);
        writeTx(8'hC3);
        mosiBytes = '{8'h96};
        runFrameA(0, 8, 6, "after reset");
        clearErrors();

        $display("[TB] randomized frames");
        for (int it = 0; it < 8; it++) begin
            m = $urandom_range(0, 3);
            half = $urandom_range(4, 9);
            nW = $urandom_range(0, 4);
            if (txModelQ.size() + nW > DEPTH_A) nW = DEPTH_A - txModelQ.size();
            for (int w = 0; w < nW; w++) writeTx(8'($urandom_range(0, 255)));
            nBytes = $urandom_range(1, 3);
            nBits = nBytes * 8;
            if ($urandom_range(0, 3) == 0) nBits = nBits - $urandom_range(1, 7);
            mosiBytes.delete();
            for (int k = 0; k < nBytes; k++) mosiBytes.push_back(8'($urandom_range(0, 255)));
            runFrameA(m, nBits, half, $sformatf("random %0d", it));
            clearErrors();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
